data_sram_responder: RTL and testbench

//   Responder end of the data-side SRAM-like interface: accepts load/store requests

---
 rtl/data_sram_responder_pkg.sv | 25 ++
 rtl/data_sram_responder_resp_fifo.sv | 79 +++++++
 rtl/data_sram_responder.sv | 81 ++++++++
 tb/tb_data_sram_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: size encodings, default
// address width and the byte-lane merge used by partial stores.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  localparam int DATA_SRAM_AW = 12;

  // Lanes with strb set take the new byte; others keep the old word's byte.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue: DEPTH entries, each with a down-timer loaded on push.
// head_ready flags a valid head whose timer has expired; hold freezes all timers.
module data_sram_responder_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2,
  parameter int DW      = 32,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW     = (LATENCY > 1) ? $clog2(LATENCY) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  input  logic          hold,
  output logic          head_ready,
  output logic [DW-1:0] head_dat,
  output logic [CW-1:0] count
);

  logic [DW-1:0] dat_q [DEPTH];
  logic [DW-1:0] dat_d [DEPTH];
  logic [TW-1:0] tmr_q [DEPTH];
  logic [TW-1:0] tmr_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    dat_d    = dat_q;
    tmr_d    = tmr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!hold) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tmr_q[i] != '0) tmr_d[i] = tmr_q[i] - TW'(1);
      end
    end
    if (push) begin
      dat_d[wr_ptr_q] = push_dat;
      tmr_d[wr_ptr_q] = TW'(LATENCY - 1);
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Data words are left as-is on reset; only control state and timers clear.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tmr_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    dat_q    <= dat_d;
    tmr_q    <= tmr_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  assign head_ready = (count_q != '0) && (tmr_q[rd_ptr_q] == '0);
  assign head_dat   = dat_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word memory with byte-lane stores, loads sampled at
// acceptance, in-order data_ok/rdata a fixed LATENCY later, up to DEPTH in flight.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int MEM_AW  = DATA_SRAM_AW,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        resp_hold
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              mem_we;
  logic [31:0]       mem_wdat;
  logic [31:0]       push_dat;
  logic              reset_q, reset_d;
  logic              head_ready;
  logic [31:0]       head_dat;
  logic [CW-1:0]     count;

  // Size and sub-word address bits are ignored, as are address bits above the memory.
  logic unused_ok;
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

  assign idx = data_sram_addr[MEM_AW+1:2];

  // No pop bypass: a full queue refuses even while its head is leaving.
  assign data_sram_addr_ok = !reset && !reset_q && (count < CW'(DEPTH));
  assign accept            = data_sram_req && data_sram_addr_ok;

  always_comb begin
    reset_d  = reset;
    mem_we   = accept && data_sram_wr;
    mem_wdat = byte_merge(mem[idx], data_sram_wdata, data_sram_wstrb);
    push_dat = data_sram_wr ? 32'h0 : mem[idx];
  end

  always_ff @(posedge clk) begin
    reset_q <= reset_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= mem_wdat;
  end

  data_sram_responder_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .DW      (32)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_dat   (push_dat),
    .pop        (data_sram_data_ok),
    .hold       (resp_hold),
    .head_ready (head_ready),
    .head_dat   (head_dat),
    .count      (count)
  );

  assign data_sram_data_ok = head_ready && !resp_hold && !reset;
  assign data_sram_rdata   = data_sram_data_ok ? head_dat : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: directed stores/loads push expected
// responses; a negedge monitor pops and compares on every data_ok.
module tb_data_sram_responder;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        resp_hold;

  always #5 clk = ~clk;

  data_sram_responder #(.MEM_AW(12), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .resp_hold         (resp_hold)
  );

  typedef struct {
    logic [31:0] rdata;
    int          acc;
    bit          exact;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Monitor: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_data_ok actual=1 required=0 rdata=%h", rdata);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.name, rdata, mon_e.rdata);
        if (mon_e.exact) chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc), 32'(LATENCY - 1));
      end
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
  end

  // Drive a request and hold it until accepted; returns just after the accepting edge.
  task automatic do_req(input logic w, input logic [3:0] strb, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exact, input string name);
    req   = 1'b1;
    wr    = w;
    wstrb = strb;
    addr  = a;
    wdata = wd;
    size  = 2'd2;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        @(posedge clk);
        #1;
        sb.push_back('{rdata: exp_rd, acc: cyc, exact: exact, name: name});
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_accept required=accept", name);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; resp_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_ok", addr_ok, 1'b0);
    chk("reset_data_ok", data_ok, 1'b0);
    chk("reset_count", 32'(dut.u_fifo.count_q), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_addr_ok", addr_ok, 1'b1);
    @(posedge clk); #1;

    // 1: store then load, same word
    do_req(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b1, "t1_sw");
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1, "t1_lw");
    idle(5);

    // 2: byte-lane store over a full word
    do_req(1'b1, 4'hF, 32'h0000_0104, 32'h1122_3344, 32'h0, 1'b1, "t2_sw");
    do_req(1'b1, 4'b0010, 32'h0000_0104, 32'h0000_AB00, 32'h0, 1'b1, "t2_sb");
    do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h1122_AB44, 1'b1, "t2_lw");
    idle(5);

    // 6: upper address bits alias onto the same word
    do_req(1'b1, 4'hF, 32'h4000_0008, 32'hCAFE_F00D, 32'h0, 1'b1, "t6_sw");
    do_req(1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b1, "t6_lw");
    idle(5);

    // 4: preload four words, then four loads in order
    do_req(1'b1, 4'hF, 32'h0000_0200, 32'hA0A0_0001, 32'h0, 1'b1, "t4_sw0");
    do_req(1'b1, 4'hF, 32'h0000_0204, 32'hB1B1_0002, 32'h0, 1'b1, "t4_sw1");
    do_req(1'b1, 4'hF, 32'h0000_0208, 32'hC2C2_0003, 32'h0, 1'b1, "t4_sw2");
    do_req(1'b1, 4'hF, 32'h0000_020C, 32'hD3D3_0004, 32'h0, 1'b1, "t4_sw3");
    do_req(1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'hA0A0_0001, 1'b1, "t4_lw0");
    do_req(1'b0, 4'h0, 32'h0000_0204, 32'h0, 32'hB1B1_0002, 1'b1, "t4_lw1");
    do_req(1'b0, 4'h0, 32'h0000_0208, 32'h0, 32'hC2C2_0003, 1'b1, "t4_lw2");
    do_req(1'b0, 4'h0, 32'h0000_020C, 32'h0, 32'hD3D3_0004, 1'b1, "t4_lw3");
    idle(5);

    // 3: hold responses, fill the queue, third request must wait
    resp_hold = 1'b1;
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, "t3_lw0");
    do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h1122_AB44, 1'b0, "t3_lw1");
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full_addr_ok", addr_ok, 1'b0);
      chk("t3_hold_data_ok", data_ok, 1'b0);
    end
    @(posedge clk); #1;
    resp_hold = 1'b0;
    do_req(1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, "t3_lw2");
    idle(6);

    // 5: reset with two responses pending
    resp_hold = 1'b1;
    do_req(1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'hA0A0_0001, 1'b0, "t5_lw0");
    do_req(1'b0, 4'h0, 32'h0000_0204, 32'h0, 32'hB1B1_0002, 1'b0, "t5_lw1");
    sb.delete();
    req = 1'b0; reset = 1'b1; resp_hold = 1'b0;
    @(negedge clk);
    chk("t5_reset_addr_ok", addr_ok, 1'b0);
    chk("t5_reset_data_ok", data_ok, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_count", 32'(dut.u_fifo.count_q), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_addr_ok_after", addr_ok, 1'b1);
    chk("t5_count_after", 32'(dut.u_fifo.count_q), 32'h0);
    @(posedge clk); #1;
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1, "t5_lw_old0");
    do_req(1'b0, 4'h0, 32'h0000_020C, 32'h0, 32'hD3D3_0004, 1'b1, "t5_lw_old1");
    req = 1'b0;

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
